// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_ctrl
//  Description : UART receive-path controller. Detects the start bit, runs the
//                oversample-tick and bit counters, enables the data sampler
//                and deserializer, checks start/parity/stop against the
//                sampled bit and pulses data_valid for a clean frame.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic [5:0]       prescale,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  input  logic             sampled_bit,
  input  logic [WIDTH-1:0] P_DATA,
  output logic             dat_samp_en,
  output logic             deser_en,
  output logic [5:0]       edge_cnt,
  output logic [3:0]       bit_cnt,
  output logic             data_valid,
  output logic             par_err,
  output logic             stp_err
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [3:0] c_last_data = 4'(WIDTH);
  localparam logic [3:0] c_deser_hi  = 4'(WIDTH + 1);
  localparam logic [5:0] c_p_default = 6'd8;

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_p;
  logic       r_par_en;
  logic       r_par_typ;
  logic [5:0] r_edge;
  logic [3:0] r_bit;
  logic       r_par_err;
  logic       r_stp_err;
  logic [5:0] w_p_sel;
  logic       w_start;
  logic       w_wrap;
  logic       w_chk;
  logic       w_exp_par;

  // Unsupported oversampling ratios fall back to 8
  always_comb begin
    case (prescale)
      6'd16:   w_p_sel = 6'd16;
      6'd32:   w_p_sel = 6'd32;
      default: w_p_sel = c_p_default;
    endcase
  end

  assign w_start   = (r_state == S_IDLE) && !RX_IN;
  assign w_wrap    = (r_edge == (r_p - 6'd1));
  assign w_chk     = (r_edge == ((r_p >> 1) + 6'd2));
  assign w_exp_par = (^P_DATA) ^ r_par_typ;

  // State register
  always_ff @(posedge CLK) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // Next-state logic: each bit period ends at the tick-counter wrap
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (!RX_IN) w_next = S_START;
      S_START: begin
        if (w_chk && sampled_bit) w_next = S_IDLE;
        else if (w_wrap)          w_next = S_DATA;
      end
      S_DATA:   if (w_wrap && (r_bit == c_last_data)) w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: if (w_wrap) w_next = S_STOP;
      S_STOP:   if (w_wrap) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Frame parameters are captured at start detection and held for the frame
  always_ff @(posedge CLK) begin
    if (!RST) begin
      r_p       <= c_p_default;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
    end else if (w_start) begin
      r_p       <= w_p_sel;
      r_par_en  <= PAR_EN;
      r_par_typ <= PAR_TYP;
    end
  end

  // Tick/bit counters; the detection cycle already counts as tick 0
  always_ff @(posedge CLK) begin
    if (!RST || (w_next == S_IDLE)) begin
      r_edge <= 6'd0;
      r_bit  <= 4'd0;
    end else if (r_state == S_IDLE) begin
      r_edge <= 6'd1;
      r_bit  <= 4'd0;
    end else if (w_wrap) begin
      r_edge <= 6'd0;
      r_bit  <= r_bit + 4'd1;
    end else begin
      r_edge <= r_edge + 6'd1;
    end
  end

  // Sticky error flags, cleared when the next start bit is detected
  always_ff @(posedge CLK) begin
    if (!RST || w_start) begin
      r_par_err <= 1'b0;
      r_stp_err <= 1'b0;
    end else begin
      if ((r_state == S_PARITY) && w_chk && (sampled_bit != w_exp_par)) r_par_err <= 1'b1;
      if ((r_state == S_STOP) && w_chk && !sampled_bit)                 r_stp_err <= 1'b1;
    end
  end

  assign dat_samp_en = (r_state != S_IDLE);
  assign deser_en    = (r_state != S_IDLE) && (r_bit >= 4'd2) && (r_bit <= c_deser_hi);
  assign edge_cnt    = r_edge;
  assign bit_cnt     = r_bit;
  assign data_valid  = (r_state == S_STOP) && w_wrap && !r_par_err && !r_stp_err;
  assign par_err     = r_par_err;
  assign stp_err     = r_stp_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_ctrl
//  Description : Self-checking bench for uart_rx_ctrl. Expected counter,
//                enable, valid and flag values come from frame arithmetic
//                (cycle k of a frame is bit k/P, tick k%P).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_ctrl;

  logic       CLK;
  logic       RST;
  logic       RX_IN;
  logic [5:0] prescale;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       sampled_bit;
  logic [7:0] P_DATA;
  logic       dat_samp_en;
  logic       deser_en;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       data_valid;
  logic       par_err;
  logic       stp_err;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int dv_cyc = -1;
  logic m_pe = 1'b0;
  logic m_se = 1'b0;
  logic [5:0] cfg_p   = 6'd8;
  logic       cfg_pen = 1'b0;
  logic       cfg_pty = 1'b0;

  uart_rx_ctrl #(.WIDTH(8)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .prescale(prescale),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit),
    .P_DATA(P_DATA), .dat_samp_en(dat_samp_en), .deser_en(deser_en),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .data_valid(data_valid),
    .par_err(par_err), .stp_err(stp_err)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge
  task automatic step(input logic rst, input logic rx, input logic sb,
                      input logic [5:0] e_edge, input logic [3:0] e_bit,
                      input logic e_samp, input logic e_deser, input logic e_dv,
                      input logic e_pe, input logic e_se, input logic scramble);
    @(posedge CLK);
    #1;
    RST = rst;
    RX_IN = rx;
    sampled_bit = sb;
    if (scramble) begin
      prescale = 6'($urandom_range(0, 63));
      PAR_EN   = 1'($urandom_range(0, 1));
      PAR_TYP  = 1'($urandom_range(0, 1));
    end else begin
      prescale = cfg_p;
      PAR_EN   = cfg_pen;
      PAR_TYP  = cfg_pty;
    end
    @(negedge CLK);
    cyc++;
    chk("edge_cnt", 32'(edge_cnt), 32'(e_edge));
    chk("bit_cnt", 32'(bit_cnt), 32'(e_bit));
    chk("dat_samp_en", 32'(dat_samp_en), 32'(e_samp));
    chk("deser_en", 32'(deser_en), 32'(e_deser));
    chk("data_valid", 32'(data_valid), 32'(e_dv));
    chk("par_err", 32'(par_err), 32'(e_pe));
    chk("stp_err", 32'(stp_err), 32'(e_se));
    if (data_valid === 1'b1) dv_cyc = cyc;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++)
      step(1'b1, 1'b1, 1'b1, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0, m_pe, m_se, 1'b0);
  endtask

  // Full frame; abort_k >= 0 pulls reset low during that frame cycle
  task automatic frame(input logic [5:0] praw, input logic pen, input logic pty,
                       input logic [7:0] d, input logic flip, input logic stopv,
                       input int abort_k);
    int p, s, n, bi, ei;
    logic bits [0:10];
    logic pe_bad, se_bad, pe_x, se_x, dv_x;
    p = (praw == 6'd16 || praw == 6'd32) ? int'(praw) : 8;
    s = p / 2 + 2;
    n = 10 + int'(pen);
    for (int i = 0; i <= 10; i++) bits[i] = 1'b1;
    bits[0] = 1'b0;
    for (int i = 1; i <= 8; i++) bits[i] = d[i-1];
    if (pen) bits[9] = (^d) ^ pty ^ flip;
    bits[n-1] = stopv;
    pe_bad = pen && flip;
    se_bad = !stopv;
    cfg_p = praw; cfg_pen = pen; cfg_pty = pty;
    P_DATA = d;
    for (int k = 0; k < n * p; k++) begin
      bi = k / p;
      ei = k % p;
      pe_x = (k == 0) ? m_pe : (pe_bad && (k > 9 * p + s));
      se_x = (k == 0) ? m_se : (se_bad && (k > (n - 1) * p + s));
      dv_x = (k == n * p - 1) && !pe_bad && !se_bad;
      step(k != abort_k, bits[bi], bits[bi], 6'(ei), 4'(bi), k != 0,
           (bi >= 2) && (bi <= 9), dv_x, pe_x, se_x, k != 0);
      if (k == abort_k) begin
        m_pe = 1'b0;
        m_se = 1'b0;
        return;
      end
    end
    m_pe = pe_bad;
    m_se = se_bad;
  endtask

  // RX_IN low for two cycles while the sampler keeps reporting 1
  task automatic glitch(input logic [5:0] praw);
    int p, s;
    p = (praw == 6'd16 || praw == 6'd32) ? int'(praw) : 8;
    s = p / 2 + 2;
    cfg_p = praw;
    for (int k = 0; k <= s; k++)
      step(1'b1, (k < 2) ? 1'b0 : 1'b1, 1'b1, 6'(k), 4'd0, k != 0, 1'b0, 1'b0,
           (k == 0) ? m_pe : 1'b0, (k == 0) ? m_se : 1'b0, 1'b0);
    m_pe = 1'b0;
    m_se = 1'b0;
  endtask

  initial begin
    int t_first;
    logic [5:0] rp;
    logic rpen, rflip, rstop;
    RST = 1'b0; RX_IN = 1'b1; prescale = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    sampled_bit = 1'b1; P_DATA = 8'h00;

    // Reset state
    step(1'b0, 1'b1, 1'b1, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 6'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(3);

    // P=8, no parity, 0xA5: valid on cycle 79 after detection
    frame(6'd8, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, -1);
    idle(2);

    // P=16, even parity, good then flipped parity bit
    frame(6'd16, 1'b1, 1'b0, 8'h37, 1'b0, 1'b1, -1);
    idle(2);
    frame(6'd16, 1'b1, 1'b0, 8'h37, 1'b1, 1'b1, -1);
    idle(2);

    // Stop bit error, then flags clear at the next start
    frame(6'd8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, -1);
    idle(2);
    frame(6'd8, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b1, -1);
    idle(1);

    // Start-bit glitch returns to idle after tick 6
    glitch(6'd8);
    idle(3);

    // Back-to-back frames at P=32, pulses 320 cycles apart
    frame(6'd32, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, -1);
    t_first = dv_cyc;
    frame(6'd32, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b1, -1);
    chk("b2b_gap", 32'(dv_cyc - t_first), 32'd320);
    idle(2);

    // Reset in the middle of the data bits, then a clean frame
    frame(6'd8, 1'b0, 1'b0, 8'h99, 1'b0, 1'b1, 30);
    idle(2);
    frame(6'd8, 1'b0, 1'b0, 8'h66, 1'b0, 1'b1, -1);

    // Illegal prescale falls back to 8
    frame(6'd20, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1, -1);
    idle(1);

    // Random frames with random ratio, parity, errors and gaps
    for (int i = 0; i < 14; i++) begin
      case ($urandom_range(0, 3))
        0:       rp = 6'd8;
        1:       rp = 6'd16;
        2:       rp = 6'd32;
        default: rp = 6'($urandom_range(0, 63));
      endcase
      rpen  = 1'($urandom_range(0, 1));
      rflip = rpen && ($urandom_range(0, 3) == 0);
      rstop = ($urandom_range(0, 4) != 0);
      frame(rp, rpen, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), rflip, rstop, -1);
      idle($urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
